cpu_memory: RTL and testbench

- Memory stage, directly downstream of the execute stage; consumes its 83-bit output bundle and produces a 39-bit writeback bundle for the register-file writeback stage.
- Performs loads and stores over a single-outstanding request/ready data bus.
- Handles byte/half/word widths and sign extension, and issues a flush pulse for FENCE.
- Stalls execute via o_busy while a bus transaction is in flight.

---
 rtl/cpu_memory.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cpu_memory.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memory.sv
// Memory stage: executes loads/stores over a single-outstanding request/ready bus and emits the writeback bundle.
// Optional: define CPU_MEMORY_MISALIGNED_EN to split word-crossing misaligned accesses into two bus transactions.

module cpu_memory #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [82:0] i_data,
   output logic        o_busy,
   output logic [38:0] o_data,
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_wmask,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata,
   output logic        o_flush,
   output logic        o_fault
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_READ   = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd3;
`ifdef CPU_MEMORY_MISALIGNED_EN
   localparam logic [2:0] ST_READ2  = 3'd2;
   localparam logic [2:0] ST_WRITE2 = 3'd4;
`endif

   localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                     : 32'((64'd1 << ADDR_WIDTH) - 64'd1);
   localparam logic [31:0] WORD_MASK = ADDR_MASK & ~32'd3;

   logic [2:0]  state;
   logic        last_strobe;
   logic [5:0]  lat_rd;
   logic [1:0]  lat_width;
   logic [1:0]  lat_offset;
   logic        lat_signed;
   logic        lat_strobe;

   logic        in_strobe;
   logic [5:0]  in_rd;
   logic [31:0] in_value;
   logic        in_read;
   logic        in_write;
   logic        in_flush;
   logic [1:0]  in_width;
   logic        in_signed;
   logic [31:0] in_address;
   logic [1:0]  offset;
   logic        unused_inst_rd;

   logic        new_inst;
   logic        mem_op;
   logic        bad_access;
   logic        ready_ok;
   logic [3:0]  base_mask;
   logic [31:0] store_wdata;
   logic [3:0]  store_wmask;
   logic [31:0] raw_word;
   logic [31:0] load_value;

   assign in_strobe      = i_data[82];
   assign in_rd          = i_data[81:76];
   assign in_value       = i_data[75:44];
   assign in_read        = i_data[43];
   assign in_write       = i_data[42];
   assign in_flush       = i_data[41];
   assign in_width       = i_data[40:39];
   assign in_signed      = i_data[38];
   assign in_address     = i_data[37:6];
   assign offset         = in_address[1:0];
   assign unused_inst_rd = ^i_data[5:0];

   assign mem_op   = in_read | in_write;
   assign new_inst = (state == ST_IDLE) & ~o_fault & (in_strobe != last_strobe);
   assign ready_ok = i_bus_ready & o_bus_request;

   // A fault parks the stage: execute stays stalled until reset clears it.
   assign o_busy = i_reset & ((state != ST_IDLE) | o_fault | (new_inst & mem_op));

   always_comb begin
      base_mask = 4'b0000;
      case (in_width)
         2'd0:    base_mask = 4'b0001;
         2'd1:    base_mask = 4'b0011;
         2'd2:    base_mask = 4'b1111;
         default: base_mask = 4'b0000;
      endcase
   end

`ifdef CPU_MEMORY_MISALIGNED_EN
   logic        crosses;
   logic        lat_cross;
   logic [31:0] lo_word;
   logic [31:0] wdata_hi;
   logic [3:0]  wmask_hi;
   logic [63:0] wdata_wide;
   logic [7:0]  wmask_wide;
   logic [63:0] merged;

   assign crosses     = ((in_width == 2'd1) && (offset == 2'd3)) ||
                        ((in_width == 2'd2) && (offset != 2'd0));
   assign bad_access  = (in_width == 2'd3);
   assign wdata_wide  = {32'd0, in_value} << {offset, 3'b000};
   assign wmask_wide  = {4'd0, base_mask} << offset;
   assign store_wdata = wdata_wide[31:0];
   assign store_wmask = wmask_wide[3:0];
   // Second half of a split load: earlier word supplies the low lanes.
   assign merged      = (state == ST_READ2) ? {i_bus_rdata, lo_word} : {32'd0, i_bus_rdata};
   assign raw_word    = 32'(merged >> {lat_offset, 3'b000});
`else
   assign bad_access  = (in_width == 2'd3) ||
                        ((in_width == 2'd1) && offset[0]) ||
                        ((in_width == 2'd2) && (offset != 2'd0));
   assign store_wdata = in_value << {offset, 3'b000};
   assign store_wmask = base_mask << offset;
   assign raw_word    = i_bus_rdata >> {lat_offset, 3'b000};
`endif

   always_comb begin
      load_value = raw_word;
      case (lat_width)
         2'd0:    load_value = {{24{lat_signed & raw_word[7]}}, raw_word[7:0]};
         2'd1:    load_value = {{16{lat_signed & raw_word[15]}}, raw_word[15:0]};
         default: load_value = raw_word;
      endcase
   end

   // Stage sequencer: accepts one instruction in IDLE, runs its bus transaction(s), then toggles the writeback strobe.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state         <= ST_IDLE;
         last_strobe   <= 1'b0;
         lat_rd        <= 6'd0;
         lat_width     <= 2'd0;
         lat_offset    <= 2'd0;
         lat_signed    <= 1'b0;
         lat_strobe    <= 1'b0;
         o_data        <= 39'd0;
         o_bus_request <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_address <= 32'd0;
         o_bus_wdata   <= 32'd0;
         o_bus_wmask   <= 4'd0;
         o_flush       <= 1'b0;
         o_fault       <= 1'b0;
`ifdef CPU_MEMORY_MISALIGNED_EN
         lat_cross     <= 1'b0;
         lo_word       <= 32'd0;
         wdata_hi      <= 32'd0;
         wmask_hi      <= 4'd0;
`endif
      end else begin
         o_flush <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (new_inst) begin
                  if (!mem_op) begin
                     o_data      <= {~o_data[38], in_rd, in_value};
                     last_strobe <= in_strobe;
                     o_flush     <= in_flush;
                  end else if (bad_access) begin
                     o_fault <= 1'b1;
                  end else begin
                     lat_rd        <= in_rd;
                     lat_width     <= in_width;
                     lat_offset    <= offset;
                     lat_signed    <= in_signed;
                     lat_strobe    <= in_strobe;
                     o_bus_request <= 1'b1;
                     o_bus_address <= in_address & WORD_MASK;
`ifdef CPU_MEMORY_MISALIGNED_EN
                     lat_cross     <= crosses;
                     wdata_hi      <= wdata_wide[63:32];
                     wmask_hi      <= wmask_wide[7:4];
`endif
                     if (in_read) begin
                        o_bus_rw <= 1'b0;
                        state    <= ST_READ;
                     end else begin
                        o_bus_rw    <= 1'b1;
                        o_bus_wdata <= store_wdata;
                        o_bus_wmask <= store_wmask;
                        state       <= ST_WRITE;
                     end
                  end
               end
            end
            ST_READ: begin
               if (ready_ok) begin
`ifdef CPU_MEMORY_MISALIGNED_EN
                  if (lat_cross) begin
                     lo_word       <= i_bus_rdata;
                     o_bus_address <= (o_bus_address + 32'd4) & WORD_MASK;
                     state         <= ST_READ2;
                  end else begin
                     o_bus_request <= 1'b0;
                     o_data        <= {~o_data[38], lat_rd, load_value};
                     last_strobe   <= lat_strobe;
                     state         <= ST_IDLE;
                  end
`else
                  o_bus_request <= 1'b0;
                  o_data        <= {~o_data[38], lat_rd, load_value};
                  last_strobe   <= lat_strobe;
                  state         <= ST_IDLE;
`endif
               end
            end
            ST_WRITE: begin
               if (ready_ok) begin
`ifdef CPU_MEMORY_MISALIGNED_EN
                  if (lat_cross) begin
                     o_bus_address <= (o_bus_address + 32'd4) & WORD_MASK;
                     o_bus_wdata   <= wdata_hi;
                     o_bus_wmask   <= wmask_hi;
                     state         <= ST_WRITE2;
                  end else begin
                     o_bus_request <= 1'b0;
                     o_data        <= {~o_data[38], 6'd0, 32'd0};
                     last_strobe   <= lat_strobe;
                     state         <= ST_IDLE;
                  end
`else
                  o_bus_request <= 1'b0;
                  o_data        <= {~o_data[38], 6'd0, 32'd0};
                  last_strobe   <= lat_strobe;
                  state         <= ST_IDLE;
`endif
               end
            end
`ifdef CPU_MEMORY_MISALIGNED_EN
            ST_READ2: begin
               if (ready_ok) begin
                  o_bus_request <= 1'b0;
                  o_data        <= {~o_data[38], lat_rd, load_value};
                  last_strobe   <= lat_strobe;
                  state         <= ST_IDLE;
               end
            end
            ST_WRITE2: begin
               if (ready_ok) begin
                  o_bus_request <= 1'b0;
                  o_data        <= {~o_data[38], 6'd0, 32'd0};
                  last_strobe   <= lat_strobe;
                  state         <= ST_IDLE;
               end
            end
`endif
            default: begin
               o_bus_request <= 1'b0;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_memory.sv
// Self-checking bench for cpu_memory: a transaction-level expectation model checked every cycle,
// plus directed scenarios with hand-computed literal results.

module tb_cpu_memory;

`ifdef CPU_MEMORY_MISALIGNED_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic [82:0] in_data;
   logic        o_busy;
   logic [38:0] o_data;
   logic        o_bus_request;
   logic        o_bus_rw;
   logic [31:0] o_bus_address;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_wmask;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic        o_flush;
   logic        o_fault;

   int n_checks = 0;
   int n_fail   = 0;
   int req_cycles = 0;

   logic        strobe;
   logic [38:0] exp_data;
   logic        exp_flush;
   logic        exp_fault;
   logic        exp_req;
   logic        exp_rw;
   logic [31:0] exp_addr;
   logic [31:0] exp_wdata;
   logic [3:0]  exp_wmask;

   always #5 clock = ~clock;

   cpu_memory #(.ADDR_WIDTH(32)) dut (
      .i_clock      (clock),
      .i_reset      (reset_n),
      .i_data       (in_data),
      .o_busy       (o_busy),
      .o_data       (o_data),
      .o_bus_request(o_bus_request),
      .o_bus_rw     (o_bus_rw),
      .o_bus_address(o_bus_address),
      .o_bus_wdata  (o_bus_wdata),
      .o_bus_wmask  (o_bus_wmask),
      .i_bus_ready  (bus_ready),
      .i_bus_rdata  (bus_rdata),
      .o_flush      (o_flush),
      .o_fault      (o_fault)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [82:0] pack(input logic s, input logic [5:0] rd, input logic [31:0] v,
                                        input logic rdop, input logic wrop, input logic fl,
                                        input logic [1:0] w, input logic sg, input logic [31:0] a);
      return {s, rd, v, rdop, wrop, fl, w, sg, a, 6'd0};
   endfunction

   function automatic int model_nbytes(input logic [1:0] w);
      return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_crosses(input logic [1:0] w, input logic [1:0] off);
      return (int'(off) + model_nbytes(w)) > 4;
   endfunction

   // Load value: pick bytes from the two-word window, then truncate and sign-fold arithmetically.
   function automatic logic [31:0] model_load(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [1:0] off, input logic [1:0] w, input logic sg);
      logic [63:0] both;
      logic [31:0] v;
      int nb;
      both = {hi, lo};
      v = 32'(both >> (8 * off));
      nb = model_nbytes(w);
      if (nb < 4) begin
         v = v % (32'd1 << (8 * nb));
         if (sg && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
      end
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] v, input logic [1:0] off, input bit hi);
      logic [63:0] x;
      x = {32'd0, v} << (8 * off);
      return hi ? x[63:32] : x[31:0];
   endfunction

   function automatic logic [3:0] model_wmask(input logic [1:0] w, input logic [1:0] off, input bit hi);
      logic [7:0] m;
      m = 8'd0;
      for (int i = 0; i < model_nbytes(w); i++) m[int'(off) + i] = 1'b1;
      return hi ? m[7:4] : m[3:0];
   endfunction

   // Every-cycle comparison against the expectation model, sampled mid-cycle.
   always @(negedge clock) begin
      if (o_bus_request) req_cycles++;
      check_output("o_data", o_data, exp_data);
      check_output("o_flush", o_flush, exp_flush);
      check_output("o_fault", o_fault, exp_fault);
      check_output("o_bus_request", o_bus_request, exp_req);
      if (exp_req) begin
         check_output("o_bus_address", o_bus_address, exp_addr);
         check_output("o_bus_rw", o_bus_rw, exp_rw);
         if (exp_rw) begin
            check_output("o_bus_wdata", o_bus_wdata, exp_wdata);
            check_output("o_bus_wmask", o_bus_wmask, exp_wmask);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_word(input logic [31:0] d, input int wait_n);
      for (int k = 1; k <= wait_n; k++) begin
         if (k == wait_n) begin
            bus_ready = 1'b1;
            bus_rdata = d;
         end
         tick();
         if (k < wait_n) check_output("busy_in_flight", o_busy, 1);
      end
      bus_ready = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [5:0] rd, input logic [31:0] v, input logic fl);
      strobe = ~strobe;
      in_data = pack(strobe, rd, v, 1'b0, 1'b0, fl, 2'd2, 1'b0, 32'h0);
      #1 check_output("busy_alu", o_busy, 0);
      tick();
      exp_data = {~exp_data[38], rd, v};
      exp_flush = fl;
      check_output("busy_alu_after", o_busy, 0);
      tick();
      exp_flush = 1'b0;
   endtask

   task automatic load_op(input logic [31:0] a, input logic [1:0] w, input logic sg, input logic [5:0] rd,
                          input logic [31:0] lo, input logic [31:0] hi, input int wait_n,
                          output logic [31:0] got);
      bit split;
      split = SPLIT && model_crosses(w, a[1:0]);
      strobe = ~strobe;
      in_data = pack(strobe, rd, 32'h0, 1'b1, 1'b0, 1'b0, w, sg, a);
      #1 check_output("busy_load_start", o_busy, 1);
      tick();
      exp_req = 1'b1;
      exp_rw = 1'b0;
      exp_addr = a & 32'hFFFF_FFFC;
      bus_word(lo, wait_n);
      if (split) begin
         exp_addr = exp_addr + 32'd4;
         bus_word(hi, wait_n);
      end
      exp_req = 1'b0;
      exp_data = {~exp_data[38], rd, model_load(lo, split ? hi : 32'd0, a[1:0], w, sg)};
      #1 check_output("busy_load_done", o_busy, 0);
      got = o_data[31:0];
   endtask

   task automatic store_op(input logic [31:0] a, input logic [1:0] w, input logic [31:0] v, input int wait_n);
      bit split;
      split = SPLIT && model_crosses(w, a[1:0]);
      strobe = ~strobe;
      in_data = pack(strobe, 6'd17, v, 1'b0, 1'b1, 1'b0, w, 1'b0, a);
      #1 check_output("busy_store_start", o_busy, 1);
      tick();
      exp_req = 1'b1;
      exp_rw = 1'b1;
      exp_addr = a & 32'hFFFF_FFFC;
      exp_wdata = model_wdata(v, a[1:0], 1'b0);
      exp_wmask = model_wmask(w, a[1:0], 1'b0);
      bus_word(32'h0, wait_n);
      if (split) begin
         exp_addr = exp_addr + 32'd4;
         exp_wdata = model_wdata(v, a[1:0], 1'b1);
         exp_wmask = model_wmask(w, a[1:0], 1'b1);
         bus_word(32'h0, wait_n);
      end
      exp_req = 1'b0;
      exp_data = {~exp_data[38], 6'd0, 32'd0};
      #1 check_output("busy_store_done", o_busy, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      in_data = '0;
      #1;
      exp_data = '0;
      exp_flush = 1'b0;
      exp_fault = 1'b0;
      exp_req = 1'b0;
      strobe = 1'b0;
      check_output("rst_request", o_bus_request, 0);
      check_output("rst_busy", o_busy, 0);
      check_output("rst_fault", o_fault, 0);
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [31:0] got;
      int req_start;
      reset_n = 1'b0;
      in_data = '0;
      bus_ready = 1'b0;
      bus_rdata = '0;
      strobe = 1'b0;
      exp_data = '0;
      exp_flush = 1'b0;
      exp_fault = 1'b0;
      exp_req = 1'b0;
      exp_rw = 1'b0;
      exp_addr = '0;
      exp_wdata = '0;
      exp_wmask = '0;
      repeat (2) tick();
      check_output("reset_busy", o_busy, 0);
      check_output("reset_data", o_data, 0);
      check_output("reset_request", o_bus_request, 0);
      reset_n = 1'b1;
      tick();

      check_output("model_sbyte", model_load(32'h80FFEE11, 32'h0, 2'd3, 2'd0, 1'b1), 32'hFFFF_FF80);
      check_output("model_split", model_load(32'h44332211, 32'h88776655, 2'd1, 2'd2, 1'b0), 32'h5544_3322);
      check_output("model_hwdata", model_wdata(32'h0000ABCD, 2'd2, 1'b0), 32'hABCD_0000);
      check_output("model_hwmask", model_wmask(2'd1, 2'd2, 1'b0), 4'b1100);

      apply_stimulus(6'd5, 32'h1234, 1'b0);
      check_output("alu_literal", o_data, {1'b1, 6'd5, 32'h1234});

      req_start = req_cycles;
      load_op(32'h103, 2'd0, 1'b1, 6'd9, 32'h80FFEE11, 32'h0, 3, got);
      check_output("sbyte_literal", got, 32'hFFFF_FF80);
      check_output("req_held_cycles", req_cycles - req_start, 3);
      load_op(32'h102, 2'd1, 1'b0, 6'd10, 32'h80FFEE11, 32'h0, 1, got);
      check_output("uhalf_literal", got, 32'h0000_80FF);
      load_op(32'h100, 2'd1, 1'b1, 6'd11, 32'h80FFEE11, 32'h0, 2, got);
      load_op(32'h104, 2'd2, 1'b0, 6'd12, 32'hDEADBEEF, 32'h0, 1, got);
      load_op(32'h101, 2'd0, 1'b0, 6'd13, 32'h80FFEE11, 32'h0, 1, got);
      check_output("ubyte_literal", got, 32'h0000_00EE);

      store_op(32'h202, 2'd1, 32'h0000ABCD, 2);
      check_output("store_wb_zero", o_data[37:0], 38'd0);
      store_op(32'h205, 2'd0, 32'h12345678, 1);
      store_op(32'h208, 2'd2, 32'hCAFEF00D, 1);

      apply_stimulus(6'd0, 32'h0, 1'b1);

      bus_ready = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      repeat (2) tick();
      bus_ready = 1'b0;
      check_output("ready_ignored_busy", o_busy, 0);

      strobe = ~strobe;
      in_data = pack(strobe, 6'd3, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h400);
      tick();
      exp_req = 1'b1;
      exp_rw = 1'b0;
      exp_addr = 32'h400;
      repeat (2) tick();
      do_reset();
      apply_stimulus(6'd7, 32'h0000CAFE, 1'b0);
      check_output("after_reset_literal", o_data, {1'b1, 6'd7, 32'h0000CAFE});

`ifdef CPU_MEMORY_MISALIGNED_EN
      load_op(32'h301, 2'd2, 1'b0, 6'd14, 32'h44332211, 32'h88776655, 2, got);
      check_output("split_load_literal", got, 32'h5544_3322);
      load_op(32'h501, 2'd1, 1'b0, 6'd15, 32'hAABBCCDD, 32'h0, 1, got);
      check_output("half_off1_literal", got, 32'h0000_BBCC);
      store_op(32'h302, 2'd2, 32'h11223344, 1);
`else
      strobe = ~strobe;
      in_data = pack(strobe, 6'd14, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h301);
      #1 check_output("busy_misaligned", o_busy, 1);
      tick();
      exp_fault = 1'b1;
      repeat (2) tick();
      check_output("fault_blocks_busy", o_busy, 1);
      check_output("fault_literal", o_fault, 1);
      do_reset();
`endif

      strobe = ~strobe;
      in_data = pack(strobe, 6'd1, 32'h55, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h600);
      #1 check_output("busy_width3", o_busy, 1);
      tick();
      exp_fault = 1'b1;
      repeat (2) tick();
      check_output("width3_busy", o_busy, 1);
      do_reset();
      apply_stimulus(6'd2, 32'h0000_0042, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
